tt_proj_mux_harness: RTL
========================

// Module: tt_proj_mux_harness
// PURPOSE
//  Parametrised multi-slot harness: drives shared TT input buses to N_PROJ project slots,
//  one-hot enables exactly one slot, and muxes its packed {uio_oe,uio_out,uo_out} into a
//  registered 24-bit ow. Slot switches use a ready/valid select port and a reset/settle
//  sequence. Sits between the chip-level pin logic and the per-slot project wrappers.
// PARAMETERS
//  N_PROJ      20              number of project slots (2..64)
//  SEL_W       $clog2(N_PROJ)  width of slot select address
//  GAP_CYC     2               cycles all slots are disabled and held in reset on a switch (>=1)
//  SETTLE_CYC  4               cycles after enable during which ow is forced to 0 (>=1)
// PORTS
//  clk         in   1            harness clock; also forwarded to all slots
//  rst_n       in   1            async active-low reset
//  sel_valid   in   1            select request valid
//  sel_ready   out  1            select request accepted when valid&ready
//  sel_addr    in   SEL_W        requested slot index
//  ui_in       in   8            dedicated inputs, broadcast to all slots
//  uio_in      in   8            bidir inputs, broadcast to all slots
//  proj_ena    out  N_PROJ       one-hot slot enable (all zero when none active)
//  proj_rst_n  out  1            reset to slots, low in IDLE/SWITCH
//  proj_ow     in   24*N_PROJ    slot k outputs at [24k+23:24k] = {uio_oe,uio_out,uo_out}
//  ow          out  24           registered output of selected slot
//  cur_sel     out  SEL_W        index of enabled slot (valid when active=1)
//  active      out  1            1 in ACTIVE state only
//  sel_err     out  1            sticky: out-of-range select accepted; cleared only by reset
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, proj_ena=0, proj_rst_n=0, ow=0, cur_sel=0,
//    active=0, sel_err=0, counters=0. sel_ready=1 is valid from the first cycle after release.
//  - States: IDLE, SWITCH, SETTLE, ACTIVE. sel_ready=1 in IDLE and ACTIVE, 0 otherwise.
//  - IDLE: proj_ena=0, ow=0. Valid in-range accept -> SWITCH, latching the target.
//  - SWITCH: proj_ena=0, proj_rst_n=0 for exactly GAP_CYC cycles -> SETTLE.
//  - SETTLE: proj_ena[target]=1, proj_rst_n=1, cur_sel=target, ow=0 for SETTLE_CYC
//    cycles -> ACTIVE.
//  - ACTIVE: ow <= proj_ow slice[cur_sel] each cycle (1-cycle latency). A valid accept goes
//    to SWITCH the next cycle, including a reselect of the same slot, which re-runs the
//    full reset sequence. ow is cleared to 0 on entry to SWITCH.
//  - Out-of-range addr (>= N_PROJ) accepted in IDLE or ACTIVE: sel_err<=1, next state IDLE
//    with all slots disabled and proj_rst_n=0. No SWITCH.
//  - Only ui_in and uio_in are broadcast. Unselected slots are also held by ena=0.
//  - proj_ena is always one-hot or zero. It is never multi-hot, even for one cycle.
//  - Counters sized $clog2(max(GAP_CYC,SETTLE_CYC)+1). No wrap possible.
//  - Assertion of rst_n mid-sequence aborts immediately to the reset values.
//    No request is remembered.
// CONFIGURATION
//  - Macro TT_HARNESS_ACTCNT_EN.
//  - Defined: adds output act_cnt[15:0]. Resets to 0 and clears on each entry to
//    SETTLE. Increments in ACTIVE on every cycle where the new ow value differs from the
//    previous ow. Saturates at 16'hFFFF.
//  - Undefined: the port and its logic are absent. All other behaviour is identical.
// TESTING
//  1. Reset release -> proj_ena=0, ow=0, sel_ready=1, active=0, sel_err=0.
//  2. IDLE, sel addr=3, proj_ow slot3=24'hA5C3F0 -> proj_ena=0 for 2 cycles.
//     Then proj_ena=1<<3, ow=0 for 4 cycles. active=1 with ow=24'hA5C3F0, 7 cycles
//     after accept.
//  3. ACTIVE on 3, sel addr=7 -> proj_ena=0 and ow=0 next cycle, no multi-hot cycle,
//     then slot 7's value appears after GAP+SETTLE.
//  4. sel addr=25 with N_PROJ=20 -> sel_err=1, state IDLE, proj_ena=0. A later sel addr=0
//     still works and sel_err stays 1.
//  5. rst_n low during SETTLE -> outputs take reset values asynchronously, same cycle.
//  6. TT_HARNESS_ACTCNT_EN, slot toggles uo_out every cycle for 10 ACTIVE cycles
//     -> act_cnt=10. Reselect -> act_cnt=0.

Source files
------------

// File: rtl/tt_proj_mux_harness.sv
// tt_proj_mux_harness
//   Multi-slot project harness. Exactly one of N_PROJ project slots is enabled at
//   a time. The harness registers that slot's packed {uio_oe,uio_out,uo_out} word
//   onto ow. A slot switch is requested through a ready/valid select port. Each
//   switch runs a reset gap (GAP_CYC cycles, all slots disabled, slot reset low).
//   It is followed by a settle window (SETTLE_CYC cycles, target enabled, ow held
//   at 0), and only then does the slot output become visible.
//
//   Optional feature macro: TT_HARNESS_ACTCNT_EN adds the act_cnt[15:0] output.
//   act_cnt counts the ACTIVE cycles on which ow changes value, saturating at
//   16'hFFFF, and is cleared on every entry to SETTLE.
//
// Ports
//   clk, rst_n   clock (also forwarded to slots externally), async active-low reset
//   sel_valid    select request valid
//   sel_ready    select request accepted when valid & ready (IDLE/ACTIVE)
//   sel_addr     requested slot index
//   ui_in        dedicated inputs; fanned out to every slot at the parent level
//   uio_in       bidir inputs; fanned out to every slot at the parent level
//   proj_ena     one-hot slot enable (zero when no slot is enabled)
//   proj_rst_n   slot reset, low in IDLE and SWITCH
//   proj_ow      slot k output word at [24k+23:24k]
//   ow           registered output word of the selected slot
//   cur_sel      index of the enabled slot (meaningful while active=1)
//   active       high in ACTIVE only
//   sel_err      sticky flag: an out-of-range select was accepted
//   act_cnt      (TT_HARNESS_ACTCNT_EN only) count of ow changes
module tt_proj_mux_harness #(
  parameter int N_PROJ     = 20,
  parameter int SEL_W      = $clog2(N_PROJ),
  parameter int GAP_CYC    = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  input  logic [SEL_W-1:0]      sel_addr,
  input  logic [7:0]            ui_in,
  input  logic [7:0]            uio_in,
  output logic [N_PROJ-1:0]     proj_ena,
  output logic                  proj_rst_n,
  input  logic [24*N_PROJ-1:0]  proj_ow,
  output logic [23:0]           ow,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  active,
`ifdef TT_HARNESS_ACTCNT_EN
  output logic                  sel_err,
  output logic [15:0]           act_cnt
`else
  output logic                  sel_err
`endif
);

  localparam int MAX_CYC = (GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWITCH,
    S_SETTLE,
    S_ACTIVE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_target;
  logic [SEL_W-1:0]   r_cur_sel;
  logic [23:0]        r_ow;
  logic               r_sel_err;

  logic               w_accept;
  logic               w_in_range;
  logic               w_slot_on;
  logic               w_settle_entry;
  logic [23:0]        w_slice;
  logic [23:0]        w_ow_nxt;

  // The input buses reach the slots by direct wiring in the parent. They appear
  // here only so that the harness presents the complete TT pin set.
  logic               w_unused_bcast;
  assign w_unused_bcast = ^{ui_in, uio_in};

  assign sel_ready  = (r_state == S_IDLE) || (r_state == S_ACTIVE);
  assign active     = (r_state == S_ACTIVE);
  assign w_slot_on  = (r_state == S_SETTLE) || (r_state == S_ACTIVE);
  assign proj_rst_n = w_slot_on;
  assign w_accept   = sel_valid && sel_ready;
  assign w_in_range = 32'(sel_addr) < 32'(N_PROJ);
  assign w_settle_entry = (r_state == S_SWITCH) && (w_state_nxt == S_SETTLE);

  assign ow      = r_ow;
  assign cur_sel = r_cur_sel;
  assign sel_err = r_sel_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_in_range ? S_SWITCH : S_IDLE;
      S_SWITCH: if (r_cnt == GAP_LAST) w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_cnt == SETTLE_LAST) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_accept) w_state_nxt = w_in_range ? S_SWITCH : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // The enable is decoded from a single registered index, so it is one-hot or zero
  // by construction.
  always_comb begin
    proj_ena = '0;
    w_slice  = '0;
    for (int unsigned k = 0; k < N_PROJ; k++) begin
      proj_ena[k] = w_slot_on && (r_cur_sel == SEL_W'(k));
      if (r_cur_sel == SEL_W'(k)) w_slice = proj_ow[k*24 +: 24];
    end
  end

  // ow follows the slot only while ACTIVE. An accept in ACTIVE clears ow, whether
  // the request leads to SWITCH or to IDLE.
  always_comb begin
    w_ow_nxt = '0;
    if (r_state == S_ACTIVE && !w_accept) w_ow_nxt = w_slice;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_target  <= '0;
      r_cur_sel <= '0;
      r_ow      <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_ow <= w_ow_nxt;
      if (w_accept && !w_in_range) r_sel_err <= 1'b1;
      if (w_accept && w_in_range)  r_target  <= sel_addr;
      if (r_state != w_state_nxt)
        r_cnt <= '0;
      else if (r_state == S_SWITCH || r_state == S_SETTLE)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_settle_entry) r_cur_sel <= r_target;
    end
  end

`ifdef TT_HARNESS_ACTCNT_EN
  logic [15:0] r_act_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_act_cnt <= '0;
    else if (w_settle_entry)
      r_act_cnt <= '0;
    else if (r_state == S_ACTIVE && w_ow_nxt != r_ow && r_act_cnt != '1)
      r_act_cnt <= r_act_cnt + 16'd1;
  end

  assign act_cnt = r_act_cnt;
`endif

endmodule
